furv_wb_split: RTL
==================

Name: furv_wb_split

Overview:
Parametrised writeback stage for the furv pipeline, for 32-bit or 64-bit datapaths. It selects the register-file writeback value from memory, PC+4, ALU or shifter results. Loads support B/H/W/D widths with sign or zero extension. Misaligned loads that cross a bus word arrive as two memory beats; this block merges them. It sits after the memory stage and drives the register-file write port and the pipeline stall/valid chain.

Parameters:
XLEN, 32, datapath and bus width; legal values 32 or 64
NB, XLEN/8, bytes per bus beat (derived, localparam)
OFFW, $clog2(XLEN/8), width of byte offset (derived, localparam)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd  in  5  destination register
wb_sel  in  2  source select: 0 mem, 1 adjacent_pc, 2 alu, 3 shifter
mem_width  in  2  load size: 0 B, 1 H, 2 W, 3 D
mem_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
alu_results  in  XLEN  ALU result
shifter_results  in  XLEN  shifter result
adjacent_pc  in  XLEN  PC + 4
reverse_wb  in  1  bit-reverse shifter result (see Optional Feature)
mem  in  1  instruction is a load
mem_ack  in  1  memory beat valid this cycle
data_in  in  XLEN  memory beat data
byte_addr  in  OFFW  load address low bits
valid_i  in  1  instruction in this stage is valid
stall_i  in  1  downstream stall
stall_o  out  1  stall to upstream
valid_o  out  1  registered valid to next stage
wb_rel_rd  out  5  = rd
wb_rd_value  out  XLEN  writeback value
wb_rd_ready  out  1  writeback value is valid this cycle
split_o  out  1  high while waiting for the second beat of a split load

Behaviour:
- Load size S = 1 << mem_width. mem_width=3 when XLEN=32 is treated as W.
- Split condition: byte_addr + S > NB. It is evaluated only when valid_i && mem.
- FSM states:
  - IDLE: if valid_i && mem && mem_ack && split, capture data_in into lo_buf and go to HI. current_stall = 1 that cycle. Otherwise, current_stall = mem && !mem_ack, same as a single-beat load.
  - HI: current_stall = !mem_ack. On mem_ack: if stall_i = 0, go to IDLE and write back. If stall_i = 1, capture data_in into hi_buf and go to DONE.
  - DONE: current_stall = 0. The merged value comes from lo_buf and hi_buf. Go to IDLE when stall_i = 0.
  - In HI or DONE, valid_i = 0 (flush) sends the FSM to IDLE with no writeback.
- Merge: form the 2*XLEN concatenation {hi, lo}, shift right by byte_addr*8, take the low S bytes, then extend per mem_unsigned. The non-split path uses data_in alone, with the same shift and extend.
- stall_o = stall_i || current_stall. This is combinational.
- wb_rel_rd = rd.
- wb_rd_ready = valid_i && !current_stall. This is combinational.
- wb_rd_value: combinational mux on wb_sel. It is don't-care when wb_rd_ready = 0.
- valid_o: registered. When stall_i = 0, valid_o <= valid_i && !current_stall. It holds when stall_i = 1.
- split_o = (state == HI).
- Reset (including mid-split): state IDLE, valid_o 0, lo_buf and hi_buf 0. Combinational outputs follow inputs.
- Latency: aligned loads and non-loads take 0 cycles to wb_rd_ready. A split load produces wb_rd_ready in the second-beat ack cycle, at minimum 1 cycle after the first beat.

Optional Feature:
FURV_WB_REVERSE_EN:
- Defined: wb_sel=3 with reverse_wb=1 returns shifter_results bit-reversed (bit i <- bit XLEN-1-i).
- Undefined: reverse_wb is ignored, and wb_sel=3 always returns shifter_results unmodified.

Decomposition:
- Package furv_wb_pkg holds:
  - wb_sel encodings (WB_MEM, WB_PC, WB_ALU, WB_SHIFT)
  - mem_width encodings (MW_B, MW_H, MW_W, MW_D)
  - FSM state enum (ST_IDLE, ST_HI, ST_DONE)
- One sub-module, furv_load_align (combinational): inputs lo, hi, byte_addr, mem_width, mem_unsigned; output the extended value. It is parametrised by XLEN.

Test Plan:
1. XLEN=32, LB signed, byte_addr=3, one beat data_in=0x80FF_0000 -> wb_rd_value=0xFFFF_FF80, wb_rd_ready=1 same cycle; with mem_unsigned=1 -> 0x0000_0080.
2. XLEN=32, LW byte_addr=2, beat1 0xAABB_CCDD, beat2 (next cycle) 0x1122_3344 -> stall_o=1 and split_o=1 in beat1 cycle; beat2 cycle wb_rd_value=0x3344_AABB, wb_rd_ready=1; valid_o=1 next edge.
3. XLEN=32, LH signed byte_addr=3, beat1 0x80xx_xxxx, beat2 0xxxxx_xxFF, one idle cycle between beats (mem_ack=0) -> stall held for 2 cycles, result 0xFFFF_FF80.
4. XLEN=64, LD byte_addr=5, beat1 0x0807_0605_0403_0201, beat2 0x100F_0E0D_0C0B_0A09 -> 0x0D0C_0B0A_0908_0706.
5. Split LW with stall_i=1 at beat2 -> state DONE, value stable across 3 stall cycles, valid_o unchanged; on stall_i release -> IDLE, valid_o=1.
6. rst_n asserted in HI -> split_o=0, valid_o=0 immediately; after release, aligned ALU op wb_sel=2, alu_results=0x1234 -> wb_rd_value=0x1234. With FURV_WB_REVERSE_EN: wb_sel=3, reverse_wb=1, shifter_results=0x0000_0001 -> 0x8000_0000.

Source files
------------

// File: rtl/furv_wb_split_pkg.sv
// Shared encodings for the furv writeback stage: result select, load width and FSM states.
package furv_wb_pkg;

    localparam logic [1:0] WB_MEM   = 2'd0;
    localparam logic [1:0] WB_PC    = 2'd1;
    localparam logic [1:0] WB_ALU   = 2'd2;
    localparam logic [1:0] WB_SHIFT = 2'd3;

    localparam logic [1:0] MW_B = 2'd0;
    localparam logic [1:0] MW_H = 2'd1;
    localparam logic [1:0] MW_W = 2'd2;
    localparam logic [1:0] MW_D = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HI   = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A doubleword load on a 32-bit datapath degrades to a word load.
    function automatic logic [1:0] eff_width(input logic [1:0] mw, input int xlen);
        return (xlen == 32 && mw == MW_D) ? MW_W : mw;
    endfunction

endpackage

// File: rtl/furv_wb_split_if.sv
// Bus bundle between the memory stage and the writeback stage; the stage itself uses the slave modport.
interface furv_wb_split_if #(parameter int XLEN = 32);
    localparam int OFFW = $clog2(XLEN / 8);

    logic [4:0]      rd;
    logic [1:0]      wb_sel;
    logic [1:0]      mem_width;
    logic            mem_unsigned;
    logic [XLEN-1:0] alu_results;
    logic [XLEN-1:0] shifter_results;
    logic [XLEN-1:0] adjacent_pc;
    logic            reverse_wb;
    logic            mem;
    logic            mem_ack;
    logic [XLEN-1:0] data_in;
    logic [OFFW-1:0] byte_addr;
    logic            valid_i;
    logic            stall_i;
    logic            stall_o;
    logic            valid_o;
    logic [4:0]      wb_rel_rd;
    logic [XLEN-1:0] wb_rd_value;
    logic            wb_rd_ready;
    logic            split_o;

    modport master (
        output rd, wb_sel, mem_width, mem_unsigned, alu_results, shifter_results,
               adjacent_pc, reverse_wb, mem, mem_ack, data_in, byte_addr, valid_i, stall_i,
        input  stall_o, valid_o, wb_rel_rd, wb_rd_value, wb_rd_ready, split_o
    );

    modport slave (
        input  rd, wb_sel, mem_width, mem_unsigned, alu_results, shifter_results,
               adjacent_pc, reverse_wb, mem, mem_ack, data_in, byte_addr, valid_i, stall_i,
        output stall_o, valid_o, wb_rel_rd, wb_rd_value, wb_rd_ready, split_o
    );
endinterface

// File: rtl/furv_load_align.sv
// Combinational load aligner: picks S bytes at byte_addr out of {hi, lo} and sign/zero extends them.
module furv_load_align
    import furv_wb_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] hi,
    input  logic [OFFW-1:0] byte_addr,
    input  logic [1:0]      mem_width,
    input  logic            mem_unsigned,
    output logic [XLEN-1:0] value
);

    logic [XLEN-1:0] window;
    logic [XLEN-1:0] keep;
    logic            sign_bit;

    assign window = XLEN'({hi, lo} >> {byte_addr, 3'b000});

    always_comb begin
        keep     = '1;
        sign_bit = window[XLEN-1];
        case (eff_width(mem_width, XLEN))
            MW_B: begin keep = XLEN'({8{1'b1}});  sign_bit = window[7];  end
            MW_H: begin keep = XLEN'({16{1'b1}}); sign_bit = window[15]; end
            MW_W: begin keep = XLEN'({32{1'b1}}); sign_bit = window[31]; end
            default: ;
        endcase
    end

    assign value = (window & keep) | ((sign_bit && !mem_unsigned) ? ~keep : '0);

endmodule

// File: rtl/furv_wb_split.sv
// furv writeback stage: result select plus merging of loads that straddle two bus beats.
// Optional FURV_WB_REVERSE_EN adds a bit-reversed shifter result when reverse_wb is set.
module furv_wb_split
    import furv_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic             clk,
    input logic             rst_n,
    furv_wb_split_if.slave  bus
);

    localparam int NB = XLEN / 8;

    logic [1:0]      state;
    logic [XLEN-1:0] lo_buf;
    logic [XLEN-1:0] hi_buf;
    logic [XLEN-1:0] align_lo;
    logic [XLEN-1:0] align_hi;
    logic [XLEN-1:0] load_value;
    logic [XLEN-1:0] shift_value;
    logic [XLEN-1:0] wb_value;
    logic [3:0]      load_size;
    logic [4:0]      end_byte;
    logic            split;
    logic            cur_stall;
    logic            valid_q;

    assign load_size = 4'd1 << eff_width(bus.mem_width, XLEN);
    assign end_byte  = 5'(bus.byte_addr) + 5'(load_size);
    assign split     = bus.valid_i && bus.mem && (end_byte > 5'(NB));

    // While a split load is pending, the low half comes from lo_buf and the high half
    // from the live beat, or from hi_buf once the downstream stall forced us to park it.
    always_comb begin
        cur_stall = bus.mem && !bus.mem_ack;
        align_lo  = bus.data_in;
        align_hi  = '0;
        case (state)
            ST_HI: begin
                cur_stall = !bus.mem_ack;
                align_lo  = lo_buf;
                align_hi  = bus.data_in;
            end
            ST_DONE: begin
                cur_stall = 1'b0;
                align_lo  = lo_buf;
                align_hi  = hi_buf;
            end
            default: begin
                if (split && bus.mem_ack) cur_stall = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lo_buf  <= '0;
            hi_buf  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (!bus.stall_i) valid_q <= bus.valid_i && !cur_stall;
            case (state)
                ST_IDLE: begin
                    if (split && bus.mem_ack) begin
                        lo_buf <= bus.data_in;
                        state  <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (!bus.valid_i) begin
                        state <= ST_IDLE;
                    end else if (bus.mem_ack) begin
                        if (bus.stall_i) begin
                            hi_buf <= bus.data_in;
                            state  <= ST_DONE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!bus.valid_i || !bus.stall_i) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    furv_load_align #(.XLEN(XLEN)) u_align (
        .lo           (align_lo),
        .hi           (align_hi),
        .byte_addr    (bus.byte_addr),
        .mem_width    (bus.mem_width),
        .mem_unsigned (bus.mem_unsigned),
        .value        (load_value)
    );

`ifdef FURV_WB_REVERSE_EN
    always_comb begin
        shift_value = bus.shifter_results;
        if (bus.reverse_wb) begin
            for (int i = 0; i < XLEN; i++) shift_value[i] = bus.shifter_results[XLEN-1-i];
        end
    end
`else
    logic unused_reverse;
    assign unused_reverse = bus.reverse_wb;
    assign shift_value    = bus.shifter_results;
`endif

    always_comb begin
        case (bus.wb_sel)
            WB_MEM:  wb_value = load_value;
            WB_PC:   wb_value = bus.adjacent_pc;
            WB_ALU:  wb_value = bus.alu_results;
            default: wb_value = shift_value;
        endcase
    end

    assign bus.stall_o     = bus.stall_i || cur_stall;
    assign bus.wb_rel_rd   = bus.rd;
    assign bus.wb_rd_ready = bus.valid_i && !cur_stall;
    assign bus.wb_rd_value = wb_value;
    assign bus.valid_o     = valid_q;
    assign bus.split_o     = (state == ST_HI);

endmodule
